// File: rtl/dma_axi_mem_responder.sv
// BRAM-backed AXI-MM subordinate answering DMA INCR bursts with full-width beats.
// Optional error injection: define DMA_MEM_RESPONDER_ERR_INJECT_EN to poison bursts whose address MSB is set.
module dma_axi_mem_responder #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int ID_W       = 8,
  parameter int LEN_W      = 8,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [LEN_W-1:0]    awlen,

  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,

  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,

  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [LEN_W-1:0]    arlen,

  output logic                rvalid,
  input  logic                rready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast
);

  // state   | meaning
  // W_IDLE  | awready high, waiting for a write address
  // W_DATA  | wready high, consuming len+1 write beats
  // W_RESP  | bvalid high until bready
  // R_IDLE  | arready high, waiting for a read address
  // R_FETCH | RAM read issued for the current beat
  // R_DATA  | rvalid high, beat held until rready

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int DEPTH  = 1 << MEM_ADDR_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic aw_poison;
  logic ar_poison;

`ifdef DMA_MEM_RESPONDER_ERR_INJECT_EN
  assign aw_poison = awaddr[ADDR_W-1];
  assign ar_poison = araddr[ADDR_W-1];
`else
  assign aw_poison = 1'b0;
  assign ar_poison = 1'b0;
`endif

  // Byte-offset and upper address bits are deliberately dropped (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr, araddr};

  // ------------------------------------------------------------------
  // Write channel
  // ------------------------------------------------------------------
  w_state_t              w_state;
  w_state_t              w_state_nx;
  logic                  awready_nx;
  logic                  wready_nx;
  logic                  bvalid_nx;
  logic [MEM_ADDR_W-1:0] w_idx;
  logic [LEN_W-1:0]      w_len;
  logic [LEN_W-1:0]      w_cnt;
  logic                  w_err;
  logic                  w_err_nx;
  logic                  w_poison;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  w_final;

  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign b_hs     = bvalid & bready;
  assign w_final  = (w_cnt == w_len);
  assign w_err_nx = w_err | (wlast != w_final);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      awready <= awready_nx;
      wready  <= wready_nx;
      bvalid  <= bvalid_nx;
    end
  end

  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nx = W_DATA;
      W_DATA:  if (w_hs && w_final) w_state_nx = W_RESP;
      W_RESP:  if (b_hs) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_comb begin
    awready_nx = (w_state_nx == W_IDLE);
    wready_nx  = (w_state_nx == W_DATA);
    bvalid_nx  = (w_state_nx == W_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bid      <= '0;
      bresp    <= RESP_OKAY;
      w_idx    <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_err    <= 1'b0;
      w_poison <= 1'b0;
    end else begin
      if (aw_hs) begin
        bid      <= awid;
        w_idx    <= awaddr[OFF_W +: MEM_ADDR_W];
        w_len    <= awlen;
        w_cnt    <= '0;
        w_err    <= 1'b0;
        w_poison <= aw_poison;
      end
      if (w_hs) begin
        w_idx <= w_idx + 1'b1;
        w_cnt <= w_cnt + 1'b1;
        w_err <= w_err_nx;
        if (w_final) begin
          bresp <= (w_err_nx || w_poison) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_poison) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Read channel
  // ------------------------------------------------------------------
  r_state_t              r_state;
  r_state_t              r_state_nx;
  logic                  arready_nx;
  logic                  rvalid_nx;
  logic [MEM_ADDR_W-1:0] r_idx;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_cnt;
  logic                  r_poison;
  logic                  ar_hs;
  logic                  r_hs;

  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
    end else begin
      r_state <= r_state_nx;
      arready <= arready_nx;
      rvalid  <= rvalid_nx;
    end
  end

  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nx = R_FETCH;
      R_FETCH: r_state_nx = R_DATA;
      R_DATA:  if (r_hs) r_state_nx = rlast ? R_IDLE : R_FETCH;
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_comb begin
    arready_nx = (r_state_nx == R_IDLE);
    rvalid_nx  = (r_state_nx == R_DATA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rid      <= '0;
      r_idx    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_poison <= 1'b0;
    end else begin
      if (ar_hs) begin
        rid      <= arid;
        r_idx    <= araddr[OFF_W +: MEM_ADDR_W];
        r_len    <= arlen;
        r_cnt    <= '0;
        r_poison <= ar_poison;
      end
      if (r_hs && !rlast) begin
        r_idx <= r_idx + 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Fetch happens on the same edge as any colliding write, so the old word is returned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
      rlast <= 1'b0;
    end else if (r_state == R_FETCH) begin
      rdata <= r_poison ? '0 : mem[r_idx];
      rresp <= r_poison ? RESP_SLVERR : RESP_OKAY;
      rlast <= (r_cnt == r_len);
    end
  end

endmodule

// File: tb/tb_dma_axi_mem_responder.sv
// Directed bench for dma_axi_mem_responder: burst writes/reads, strobes, wrap, stalls, errors, reset.
module tb_dma_axi_mem_responder;
  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 512;
  localparam int ID_W       = 8;
  localparam int LEN_W      = 8;
  localparam int MEM_ADDR_W = 10;
  localparam int STRB_W     = DATA_W / 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                awvalid, awready;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [LEN_W-1:0]    awlen;
  logic                wvalid, wready;
  logic [DATA_W-1:0]   wdata;
  logic [STRB_W-1:0]   wstrb;
  logic                wlast;
  logic                bvalid, bready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                arvalid, arready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [LEN_W-1:0]    arlen;
  logic                rvalid, rready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;

  always #5 clk = ~clk;

  dma_axi_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W), .MEM_ADDR_W(MEM_ADDR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [DATA_W-1:0] wd [16];
  logic [STRB_W-1:0] ws [16];
  logic [DATA_W-1:0] er [16];

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [7:0] v);
    return {STRB_W{v}};
  endfunction

  task automatic write_burst(input logic [ADDR_W-1:0] addr, input int len, input logic [ID_W-1:0] id,
                             input int last_at, input int bhold, input logic [1:0] exp_resp);
    int n;
    n = 0;
    while (!awready && n < 20) begin tick(); n++; end
    check("awready_wait", DATA_W'(awready), 1);
    awvalid = 1'b1; awaddr = addr; awlen = LEN_W'(len); awid = id;
    tick();
    awvalid = 1'b0;
    check("wready_after_aw", DATA_W'(wready), 1);
    check("awready_low", DATA_W'(awready), 0);
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at);
      n = 0;
      while (!wready && n < 20) begin tick(); n++; end
      check("wready_beat", DATA_W'(wready), 1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("wready_done", DATA_W'(wready), 0);
    check("bvalid_rise", DATA_W'(bvalid), 1);
    for (int k = 0; k < bhold; k++) begin
      tick();
      check("bvalid_hold", DATA_W'(bvalid), 1);
      check("bid_hold", DATA_W'(bid), DATA_W'(id));
    end
    check("bid", DATA_W'(bid), DATA_W'(id));
    check("bresp", DATA_W'(bresp), DATA_W'(exp_resp));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_drop", DATA_W'(bvalid), 0);
    check("awready_back", DATA_W'(awready), 1);
  endtask

  task automatic read_burst(input logic [ADDR_W-1:0] addr, input int len, input logic [ID_W-1:0] id,
                            input int stall_at, input int stall_n, input logic [1:0] exp_resp);
    int n;
    logic [DATA_W-1:0] held;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    check("arready_wait", DATA_W'(arready), 1);
    arvalid = 1'b1; araddr = addr; arlen = LEN_W'(len); arid = id;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      check("rvalid_fetch", DATA_W'(rvalid), 0);
      tick();
      check("rvalid_lat", DATA_W'(rvalid), 1);
      if (i == stall_at) begin
        for (int k = 0; k < stall_n; k++) begin
          held = rdata;
          tick();
          check("rvalid_stall", DATA_W'(rvalid), 1);
          check("rdata_stall", rdata, held);
        end
      end
      check("rdata", rdata, er[i]);
      check("rid", DATA_W'(rid), DATA_W'(id));
      check("rresp", DATA_W'(rresp), DATA_W'(exp_resp));
      check("rlast", DATA_W'(rlast), DATA_W'(i == len));
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
    check("rvalid_end", DATA_W'(rvalid), 0);
    check("arready_back", DATA_W'(arready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; rready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", DATA_W'(awready), 0);
    check("rst_wready", DATA_W'(wready), 0);
    check("rst_bvalid", DATA_W'(bvalid), 0);
    check("rst_arready", DATA_W'(arready), 0);
    check("rst_rvalid", DATA_W'(rvalid), 0);
    check("rst_ids", DATA_W'({rid, bid}), 0);
    check("rst_rdata", rdata, 0);
    check("rst_resp_last", DATA_W'({rresp, bresp, rlast}), 0);
    reset = 1'b0;
    #1;
    check("awready_pre_edge", DATA_W'(awready), 0);
    tick();
    check("awready_post_rst", DATA_W'(awready), 1);
    check("arready_post_rst", DATA_W'(arready), 1);

    // Basic 4-beat write and readback
    for (int i = 0; i < 4; i++) begin wd[i] = pat(8'hA0 + 8'(i)); ws[i] = '1; er[i] = wd[i]; end
    write_burst(64'h40, 3, 8'd5, 3, 0, 2'b00);
    read_burst(64'h40, 3, 8'd9, -1, 0, 2'b00);
    // Byte offset and bit 16 are outside the index field
    read_burst(64'h0001_0047, 3, 8'd2, -1, 0, 2'b00);

    // Byte strobes
    wd[0] = '1; ws[0] = '1;
    write_burst(64'h0, 0, 8'd1, 0, 0, 2'b00);
    wd[0] = '0; ws[0] = 64'h0F;
    write_burst(64'h0, 0, 8'd1, 0, 0, 2'b00);
    er[0] = {{(DATA_W-32){1'b1}}, 32'h0};
    read_burst(64'h0, 0, 8'd3, -1, 0, 2'b00);

    // Index wrap from depth-1 to 0
    wd[0] = pat(8'hB0); wd[1] = pat(8'hB1); ws[0] = '1; ws[1] = '1;
    write_burst(64'hFFC0, 1, 8'd7, 1, 0, 2'b00);
    er[0] = pat(8'hB0);
    read_burst(64'hFFC0, 0, 8'd7, -1, 0, 2'b00);
    er[0] = pat(8'hB1);
    read_burst(64'h0, 0, 8'd7, -1, 0, 2'b00);
    er[0] = pat(8'hB0); er[1] = pat(8'hB1);
    read_burst(64'hFFC0, 1, 8'd8, -1, 0, 2'b00);

    // Back-pressure on B and R
    for (int i = 0; i < 3; i++) begin wd[i] = pat(8'h30 + 8'(i)); ws[i] = '1; er[i] = wd[i]; end
    write_burst(64'h400, 2, 8'h44, 2, 10, 2'b00);
    read_burst(64'h400, 2, 8'h45, 1, 5, 2'b00);

    // wlast early, then wlast missing: both SLVERR, then a clean burst clears the flag
    for (int i = 0; i < 4; i++) begin wd[i] = pat(8'h50 + 8'(i)); ws[i] = '1; end
    write_burst(64'h800, 3, 8'h0C, 1, 0, 2'b10);
    write_burst(64'h800, 3, 8'h0D, -1, 0, 2'b10);
    write_burst(64'h800, 0, 8'h0E, 0, 0, 2'b00);

    // Simultaneous AW/AR to one word: the read sees the pre-write contents
    wd[0] = pat(8'hC0); ws[0] = '1;
    write_burst(64'hA00, 0, 8'h10, 0, 0, 2'b00);
    awvalid = 1'b1; awaddr = 64'hA00; awlen = 0; awid = 8'h11;
    arvalid = 1'b1; araddr = 64'hA00; arlen = 0; arid = 8'h22;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    check("sim_wready", DATA_W'(wready), 1);
    check("sim_arready_low", DATA_W'(arready), 0);
    wvalid = 1'b1; wdata = pat(8'hD5); wstrb = '1; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    check("sim_rvalid", DATA_W'(rvalid), 1);
    check("sim_rdata_old", rdata, pat(8'hC0));
    check("sim_rid", DATA_W'(rid), 8'h22);
    check("sim_bvalid", DATA_W'(bvalid), 1);
    check("sim_bid", DATA_W'(bid), 8'h11);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    er[0] = pat(8'hD5);
    read_burst(64'hA00, 0, 8'h23, -1, 0, 2'b00);

    // Reset in the middle of a read burst
    arvalid = 1'b1; araddr = 64'h40; arlen = 3; arid = 8'h66;
    tick();
    arvalid = 1'b0;
    tick();
    check("mid_rvalid0", DATA_W'(rvalid), 1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    tick();
    check("mid_rvalid1", DATA_W'(rvalid), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_rvalid", DATA_W'(rvalid), 0);
    check("mid_rst_rlast_rid", DATA_W'({rlast, rid}), 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_arready", DATA_W'(arready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("mid_arready_back", DATA_W'(arready), 1);
    for (int i = 0; i < 4; i++) er[i] = pat(8'hA0 + 8'(i));
    read_burst(64'h40, 3, 8'h67, -1, 0, 2'b00);

`ifdef DMA_MEM_RESPONDER_ERR_INJECT_EN
    wd[0] = pat(8'hEE); wd[1] = pat(8'hEF); ws[0] = '1; ws[1] = '1;
    write_burst(64'h8000_0000_0000_0040, 1, 8'h70, 1, 0, 2'b10);
    read_burst(64'h40, 1, 8'h71, -1, 0, 2'b00);
    er[0] = '0; er[1] = '0;
    read_burst(64'h8000_0000_0000_0040, 1, 8'h72, -1, 0, 2'b10);
`else
    read_burst(64'h8000_0000_0000_0040, 3, 8'h73, -1, 0, 2'b00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dma_axi_mem_responder.md
Name: dma_axi_mem_responder

Overview:
- Synthesizable BRAM-backed AXI-MM responder (subordinate) that answers the read and write bursts the DMA engine initiates on its src/dest memory ports.
- Used as an on-FPGA scratch target and loopback endpoint, so copy modes run without host or DDR.
- Independent read and write channel FSMs share one simple dual-port RAM.
- INCR bursts only; fixed full-width beats.

Parameters:
ADDR_W, 64, byte-address width of awaddr/araddr
DATA_W, 512, data beat width in bits; power of 2, at least 64
ID_W, 8, transaction ID width
LEN_W, 8, burst length field width (beats = len+1)
MEM_ADDR_W, 10, log2 of RAM depth in DATA_W words

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awid  in  ID_W  write ID
awaddr  in  ADDR_W  write start byte address
awlen  in  LEN_W  write burst length minus 1
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables
wlast  in  1  final write beat marker
bvalid  out  1  write response valid
bready  in  1  write response ready
bid  out  ID_W  echoed awid
bresp  out  2  00 OKAY, 10 SLVERR
arvalid  in  1  read address valid
arready  out  1  read address ready
arid  in  ID_W  read ID
araddr  in  ADDR_W  read start byte address
arlen  in  LEN_W  read burst length minus 1
rvalid  out  1  read data valid
rready  in  1  read data ready
rid  out  ID_W  echoed arid
rdata  out  DATA_W  read data
rresp  out  2  read response
rlast  out  1  final read beat marker

Behaviour:
- Interface: one clock `clk`. `reset` is asynchronous and active-high.
- Reset values: all ready/valid outputs 0; rid, bid, rdata, rresp, bresp, rlast are 0. Ready outputs are registered and rise the first cycle after reset deasserts.
- Word index = addr[log2(DATA_W/8)+MEM_ADDR_W-1 : log2(DATA_W/8)].
  - Low byte-offset bits are ignored.
  - Upper bits are ignored, so the index aliases modulo depth.
  - Each beat increments the index; it wraps from depth-1 to 0.
- RAM is not reset; contents survive reset.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. An AW handshake latches id, index and len. Next cycle: W_DATA, awready=0, wready=1.
  - W_DATA: each W handshake writes the bytes enabled by wstrb and increments the beat counter.
  - wlast must match (count==len). On mismatch, set the error flag; the burst still ends on beat len+1, and extra beats are not consumed.
  - After the final beat, wready=0. Next cycle: W_RESP with bvalid=1, bid=latched id, bresp=SLVERR if the flag is set, else OKAY.
  - W_RESP: hold bvalid until bready; then W_IDLE, with awready=1 the following cycle.
- Read FSM, R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: arready=1. An AR handshake latches id, index and len; go to R_FETCH.
  - R_FETCH: issue the RAM read (1-cycle latency).
  - R_DATA: rvalid=1; rdata, rid, rresp=OKAY and rlast=(count==len) are held stable until rready.
  - On the handshake: if rlast, go to R_IDLE; else increment and go to R_FETCH.
  - Latency: AR accepted at t gives rvalid at t+2; a beat accepted at t gives the next rvalid at t+2.
- Collision (same word written and read-fetched in one cycle): read returns old data (read-before-write).
- Read and write channels are fully independent; simultaneous AW and AR are both accepted.
- Reset mid-burst: the burst is abandoned, outputs return to reset values, and beats already written remain in RAM.

Optional Feature:
- Macro: DMA_MEM_RESPONDER_ERR_INJECT_EN.
- When defined, a burst whose start address has bit ADDR_W-1 set is poisoned:
  - writes are suppressed and bresp=SLVERR;
  - every R beat has rresp=SLVERR and rdata=0;
  - handshake timing is unchanged.
- Exercises the DMA rd_rsp_err/wr_rsp_err/stopped_on_error paths.
- When undefined, that bit is ignored (aliasing as above) and responses are always OKAY unless a wlast mismatch occurs.

Test Plan:
- AW addr=0x40, len=3, id=5; 4 beats 0xA0..0xA3 with wstrb all-ones and wlast on beat 4 -> bvalid one cycle after beat 4, bid=5, bresp=00. Then AR addr=0x40, len=3, id=9 -> rdata A0..A3, rid=9, rlast only on beat 4, first rvalid 2 cycles after AR.
- Write word 0 = all 0xFF, then a 1-beat write of 0x00 with wstrb=0x0F -> readback has the low 4 bytes 0x00 and the rest 0xFF.
- Write len=1 starting at index depth-1 -> second beat lands at index 0; reads at depth-1 and at 0 confirm the wrap.
- Hold bready=0 for 10 cycles and rready=0 for 5 cycles mid-burst -> bvalid/rvalid and their payloads stay stable; no beat is lost or duplicated.
- wlast asserted on beat 2 of a len=3 burst -> 4 beats consumed and bresp=10. Separately, assert reset mid read burst -> rvalid=0 immediately; the next burst behaves normally.
- With DMA_MEM_RESPONDER_ERR_INJECT_EN: write to address with MSB set -> bresp=10, RAM unchanged; read from it -> rresp=10 and rdata=0 on all beats.
